// File: rtl/config_uart_tx.sv
// config_uart_tx: UART transmitter for configuration readback/status words.
// Each 32-bit word goes out as 4 bytes, most-significant byte first. Each byte is
// framed 8N1 (start bit, 8 data bits LSB first, STOP_BITS stop bits). A one-word
// holding buffer lets the producer queue the next word while the current one shifts.
//
// Ports:
//   CLK      in   system clock, rising edge
//   reset    in   synchronous active-high reset
//   TxData   in   [31:0] word to send, sampled on TxValid && TxReady
//   TxValid  in   producer offers TxData
//   TxReady  out  holding buffer empty
//   Tx       out  serial line, idle high, driven from a flop
//   TxBusy   out  word shifting out or word buffered
//   TxLED    out  toggles once per completed word
module config_uart_tx #(
    parameter int unsigned CLOCKS_PER_BIT = 217,
    parameter int unsigned STOP_BITS      = 1
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic [31:0] TxData,
    input  logic        TxValid,
    output logic        TxReady,
    output logic        Tx,
    output logic        TxBusy,
    output logic        TxLED
);

    localparam int unsigned      BaudW    = $clog2(CLOCKS_PER_BIT);
    localparam logic [BaudW-1:0] BaudLast = BaudW'(CLOCKS_PER_BIT - 1);
    localparam logic             StopLast = 1'(STOP_BITS - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e            r_state,    w_state_next;
    logic [31:0]       r_buf,      w_buf_next;
    logic              r_buf_full, w_buf_full_next;
    logic [31:0]       r_sh,       w_sh_next;
    logic [BaudW-1:0]  r_baud,     w_baud_next;
    logic [2:0]        r_bit,      w_bit_next;
    logic [1:0]        r_byte,     w_byte_next;
    logic              r_stop,     w_stop_next;
    logic              r_tx,       w_tx_next;
    logic              r_led,      w_led_next;

    logic              w_baud_done;
    logic [7:0]        w_cur_byte;

    assign w_baud_done = (r_baud == BaudLast);

    // Byte 0 is the most-significant byte of the shift word.
    always_comb begin
        w_cur_byte = 8'h00;
        unique case (r_byte)
            2'd0: w_cur_byte = r_sh[31:24];
            2'd1: w_cur_byte = r_sh[23:16];
            2'd2: w_cur_byte = r_sh[15:8];
            2'd3: w_cur_byte = r_sh[7:0];
            default: w_cur_byte = 8'h00;
        endcase
    end

    always_comb begin
        w_state_next    = r_state;
        w_buf_next      = r_buf;
        w_buf_full_next = r_buf_full;
        w_sh_next       = r_sh;
        w_baud_next     = r_baud;
        w_bit_next      = r_bit;
        w_byte_next     = r_byte;
        w_stop_next     = r_stop;
        w_led_next      = r_led;
        w_tx_next       = 1'b1;

        // Accept only into an empty buffer; the FSM drains only a full one, so the
        // two never collide in the same cycle.
        if (TxValid && !r_buf_full) begin
            w_buf_next      = TxData;
            w_buf_full_next = 1'b1;
        end

        // Tx is registered from the current state, so the line trails the FSM by
        // one cycle uniformly and every bit keeps its full length.
        unique case (r_state)
            StIdle: begin
                w_tx_next = 1'b1;
                if (r_buf_full) begin
                    w_sh_next       = r_buf;
                    w_buf_full_next = 1'b0;
                    w_byte_next     = 2'd0;
                    w_baud_next     = '0;
                    w_state_next    = StStart;
                end
            end
            StStart: begin
                w_tx_next = 1'b0;
                if (w_baud_done) begin
                    w_baud_next  = '0;
                    w_bit_next   = 3'd0;
                    w_state_next = StData;
                end else begin
                    w_baud_next = r_baud + BaudW'(1);
                end
            end
            StData: begin
                w_tx_next = w_cur_byte[r_bit];
                if (w_baud_done) begin
                    w_baud_next = '0;
                    if (r_bit == 3'd7) begin
                        w_stop_next  = 1'b0;
                        w_state_next = StStop;
                    end else begin
                        w_bit_next = r_bit + 3'd1;
                    end
                end else begin
                    w_baud_next = r_baud + BaudW'(1);
                end
            end
            StStop: begin
                w_tx_next = 1'b1;
                if (w_baud_done) begin
                    w_baud_next = '0;
                    if (r_stop == StopLast) begin
                        w_stop_next = 1'b0;
                        if (r_byte != 2'd3) begin
                            w_byte_next  = r_byte + 2'd1;
                            w_state_next = StStart;
                        end else begin
                            w_led_next = ~r_led;
                            // Chain straight into the buffered word with no idle gap.
                            if (r_buf_full) begin
                                w_sh_next       = r_buf;
                                w_buf_full_next = 1'b0;
                                w_byte_next     = 2'd0;
                                w_state_next    = StStart;
                            end else begin
                                w_state_next = StIdle;
                            end
                        end
                    end else begin
                        w_stop_next = r_stop + 1'b1;
                    end
                end else begin
                    w_baud_next = r_baud + BaudW'(1);
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state    <= StIdle;
            r_buf      <= '0;
            r_buf_full <= 1'b0;
            r_sh       <= '0;
            r_baud     <= '0;
            r_bit      <= '0;
            r_byte     <= '0;
            r_stop     <= 1'b0;
            r_tx       <= 1'b1;
            r_led      <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_buf      <= w_buf_next;
            r_buf_full <= w_buf_full_next;
            r_sh       <= w_sh_next;
            r_baud     <= w_baud_next;
            r_bit      <= w_bit_next;
            r_byte     <= w_byte_next;
            r_stop     <= w_stop_next;
            r_tx       <= w_tx_next;
            r_led      <= w_led_next;
        end
    end

    assign TxReady = ~r_buf_full;
    assign Tx      = r_tx;
    assign TxBusy  = (r_state != StIdle) || r_buf_full;
    assign TxLED   = r_led;

endmodule
